// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light programmer: FSM encoding, table
// geometry and the configuration entry layout.
package traffic_pkg;

    localparam int NUM_LIGHTS = 4;
    localparam int NUM_SENDS  = 8;

    localparam logic [3:0] DEFAULT_TIME = 4'd10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_RUN  = 2'd3;

    typedef struct packed {
        logic [3:0] red_time;
        logic [3:0] green_time;
        logic       start_color;
    } cfg_entry_t;

    localparam cfg_entry_t CFG_RESET = '{
        red_time:    DEFAULT_TIME,
        green_time:  DEFAULT_TIME,
        start_color: 1'b0
    };

endpackage

// File: rtl/traffic_cfg_table.sv
// Four-entry light configuration register file: one synchronous write port,
// one combinational read port indexed by light.
module traffic_cfg_table
    import traffic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we_i,
    input  logic [1:0] wr_light_i,
    input  logic       wr_color_i,
    input  logic [3:0] wr_time_i,
    input  logic       wr_start_i,
    input  logic [1:0] rd_light_i,
    output cfg_entry_t rd_entry_o
);

    cfg_entry_t table_q [NUM_LIGHTS];

    // NOTE: the table is plain flops rather than a RAM macro, so it can and must be reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LIGHTS; i++) begin
                table_q[i] <= CFG_RESET;
            end
        end else if (we_i) begin
            if (wr_color_i) begin
                table_q[wr_light_i].green_time <= wr_time_i;
            end else begin
                table_q[wr_light_i].red_time <= wr_time_i;
            end
            // Start colour belongs to the light, so every write refreshes it.
            table_q[wr_light_i].start_color <= wr_start_i;
        end
    end

    assign rd_entry_o = table_q[rd_light_i];

endmodule

// File: rtl/traffic_programmer.sv
// Streams the 4-light configuration table to the traffic lights as eight
// strobed writes, then broadcasts the run enable until stopped or restarted.
module traffic_programmer
    import traffic_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_en,
    input  logic [1:0] load_light,
    input  logic       load_color,
    input  logic [3:0] load_time,
    input  logic       load_start,
    input  logic       go,
    input  logic       stop,
    output logic       inst_send,
    output logic [1:0] traffic_sel,
    output logic       color_sel,
    output logic       start_color,
    output logic [3:0] input_time,
    output logic       is_running,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
    localparam logic [2:0] LAST_IDX = 3'(NUM_SENDS - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] gap_q, gap_d;

    logic       table_we;
    cfg_entry_t rd_entry;

    logic send_d, is_running_d, busy_d, done_d;

    assign table_we = load_en && ((state_q == ST_IDLE) || (state_q == ST_RUN));

    traffic_cfg_table u_cfg_table (
        .clk        (clk),
        .rst        (rst),
        .we_i       (table_we),
        .wr_light_i (load_light),
        .wr_color_i (load_color),
        .wr_time_i  (load_time),
        .wr_start_i (load_start),
        .rd_light_i (idx_q[2:1]),
        .rd_entry_o (rd_entry)
    );

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        unique case (state_q)
            ST_IDLE: begin
                if (go && !stop) begin
                    state_d = ST_SEND;
                    idx_d   = 3'd0;
                end
            end
            ST_SEND: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (GAP_CYCLES > 0) begin
                    state_d = ST_GAP;
                    gap_d   = GAP_LAST;
                end else if (idx_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            ST_GAP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (gap_q != 4'd0) begin
                    gap_d = gap_q - 4'd1;
                end else if (idx_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_SEND;
                    idx_d   = idx_q + 3'd1;
                end
            end
            default: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (go) begin
                    state_d = ST_SEND;
                    idx_d   = 3'd0;
                end
            end
        endcase
    end

    // Outputs trail the state by one edge; leaving a state suppresses its output at once.
    always_comb begin
        send_d       = (state_q == ST_SEND) && !stop;
        is_running_d = (state_q == ST_RUN) && (state_d == ST_RUN);
        busy_d       = ((state_q == ST_SEND) || (state_q == ST_GAP)) && (state_d != ST_IDLE);
        done_d       = is_running_d && !is_running;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 3'd0;
            gap_q       <= 4'd0;
            inst_send   <= 1'b0;
            traffic_sel <= 2'd0;
            color_sel   <= 1'b0;
            start_color <= 1'b0;
            input_time  <= 4'd0;
            is_running  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            inst_send  <= send_d;
            is_running <= is_running_d;
            busy       <= busy_d;
            done       <= done_d;
            if (send_d) begin
                traffic_sel <= idx_q[2:1];
                color_sel   <= idx_q[0];
                start_color <= rd_entry.start_color;
                input_time  <= idx_q[0] ? rd_entry.green_time : rd_entry.red_time;
            end
        end
    end

endmodule

// File: tb/tb_traffic_programmer.sv
// Directed bench for traffic_programmer: one instance with a one-cycle gap and
// one with no gap, driven by shared stimulus and checked per scenario.
module tb_traffic_programmer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_en = 1'b0;
    logic [1:0] load_light = 2'd0;
    logic       load_color = 1'b0;
    logic [3:0] load_time = 4'd0;
    logic       load_start = 1'b0;
    logic       go = 1'b0;
    logic       stop = 1'b0;

    logic       s1, col1, st1, run1, busy1, done1;
    logic [1:0] sel1;
    logic [3:0] tm1;
    logic       s0, col0, st0, run0, busy0, done0;
    logic [1:0] sel0;
    logic [3:0] tm0;

    int errors = 0;
    int checks = 0;

    logic [3:0] m_red   [4];
    logic [3:0] m_green [4];
    logic       m_start [4];

    always #5 clk = ~clk;

    traffic_programmer #(.GAP_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_light(load_light),
        .load_color(load_color), .load_time(load_time), .load_start(load_start),
        .go(go), .stop(stop), .inst_send(s1), .traffic_sel(sel1), .color_sel(col1),
        .start_color(st1), .input_time(tm1), .is_running(run1), .busy(busy1), .done(done1)
    );

    traffic_programmer #(.GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .load_en(load_en), .load_light(load_light),
        .load_color(load_color), .load_time(load_time), .load_start(load_start),
        .go(go), .stop(stop), .inst_send(s0), .traffic_sel(sel0), .color_sel(col0),
        .start_color(st0), .input_time(tm0), .is_running(run0), .busy(busy0), .done(done0)
    );

    // Packed view: [11] send, [10:9] sel, [8] colour, [7] start, [6:3] time, [2] run, [1] busy, [0] done
    function automatic logic [11:0] obs(input bit g0);
        return g0 ? {s0, sel0, col0, st0, tm0, run0, busy0, done0}
                  : {s1, sel1, col1, st1, tm1, run1, busy1, done1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_red[i]   = 4'd10;
            m_green[i] = 4'd10;
            m_start[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; go = 1'b0; stop = 1'b0; load_en = 1'b0;
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic do_load(input logic [1:0] l, input logic c, input logic [3:0] t,
                           input logic s, input logic with_go);
        load_en = 1'b1; load_light = l; load_color = c; load_time = t; load_start = s;
        go = with_go;
        tick();
        load_en = 1'b0; go = 1'b0;
        if (c) m_green[l] = t; else m_red[l] = t;
        m_start[l] = s;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    // Call right after the go edge; inj > 0 fires go plus a load into L3 green mid-sequence.
    task automatic run_and_check(input bit g0, input int inj, input string name);
        int p, r, k;
        logic [1:0]  l;
        logic        c_bit, exp_send;
        logic [7:0]  exp_f;
        logic [11:0] o, e;
        p = g0 ? 1 : 2;
        r = 1 + 8 * p;
        exp_f = 8'h00;
        o = obs(g0);
        checks++;
        if (o[11] !== 1'b0 || o[2] !== 1'b0 || o[0] !== 1'b0) begin
            errors++;
            $display("FAIL %s c=0 got=%h required send/run/done=0", name, o);
        end
        for (int c = 1; c <= r; c++) begin
            if (c == inj) begin
                go = 1'b1; load_en = 1'b1; load_light = 2'd3; load_color = 1'b1;
                load_time = 4'd1; load_start = 1'b1;
            end
            tick();
            go = 1'b0; load_en = 1'b0;
            exp_send = (((c - 1) % p) == 0) && (((c - 1) / p) < 8);
            if (exp_send) begin
                k = (c - 1) / p;
                l = 2'(k >> 1);
                c_bit = k[0];
                exp_f = {l, c_bit, m_start[l], c_bit ? m_green[l] : m_red[l]};
            end
            e = {exp_send, exp_f, (c == r), (c < r), (c == r)};
            o = obs(g0);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s c=%0d got=%h required=%h", name, c, o, e);
            end
        end
        tick();
        o = obs(g0);
        checks++;
        if (o[11] !== 1'b0 || o[2] !== 1'b1 || o[1] !== 1'b0 || o[0] !== 1'b0) begin
            errors++;
            $display("FAIL %s run_hold got=%h required run=1 others=0", name, o);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs(1'b0) !== 12'h000) begin
            errors++;
            $display("FAIL reset_gap1 got=%h required=000", obs(1'b0));
        end
        checks++;
        if (obs(1'b1) !== 12'h000) begin
            errors++;
            $display("FAIL reset_gap0 got=%h required=000", obs(1'b1));
        end
    endtask

    task automatic test_default_seq();
        do_reset();
        pulse_go();
        run_and_check(1'b0, 0, "default_seq");
    endtask

    task automatic test_load();
        do_reset();
        do_load(2'd2, 1'b1, 4'd3, 1'b1, 1'b0);
        pulse_go();
        run_and_check(1'b0, 0, "load_l2");
        // In RUN: repeated writes, then a load coincident with go from IDLE
        do_load(2'd1, 1'b0, 4'd2, 1'b0, 1'b0);
        do_load(2'd1, 1'b0, 4'd9, 1'b0, 1'b0);
        do_load(2'd3, 1'b0, 4'd6, 1'b1, 1'b0);
        do_load(2'd3, 1'b1, 4'd12, 1'b0, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        do_load(2'd0, 1'b0, 4'd7, 1'b1, 1'b1);
        run_and_check(1'b0, 0, "load_with_go");
    endtask

    task automatic test_stop();
        logic [11:0] o;
        bit bad;
        do_reset();
        pulse_go();
        for (int c = 1; c <= 7; c++) tick();
        o = obs(1'b0);
        checks++;
        if (o[11:3] !== {1'b1, 2'd1, 1'b1, 1'b0, 4'd10}) begin
            errors++;
            $display("FAIL stop_k3_send got=%h required send of L1 green", o[11:3]);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        o = obs(1'b0);
        checks++;
        if (o[11] !== 1'b0 || o[2:0] !== 3'b000) begin
            errors++;
            $display("FAIL stop_next got=%h required send/run/busy/done=0", o);
        end
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            o = obs(1'b0);
            if (o[11] !== 1'b0 || o[2:0] !== 3'b000) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL stop_idle_hold got=%h required quiet IDLE", o);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] o;
        do_reset();
        pulse_go();
        run_and_check(1'b0, 0, "b2b_first");
        pulse_go();
        run_and_check(1'b0, 5, "b2b_restart");
        go = 1'b1; stop = 1'b1;
        tick();
        go = 1'b0; stop = 1'b0;
        o = obs(1'b0);
        checks++;
        if (o[11] !== 1'b0 || o[2:0] !== 3'b000) begin
            errors++;
            $display("FAIL go_stop_now got=%h required send/run/busy/done=0", o);
        end
        for (int c = 0; c < 3; c++) tick();
        o = obs(1'b0);
        checks++;
        if (o[11] !== 1'b0 || o[2:0] !== 3'b000) begin
            errors++;
            $display("FAIL go_stop_idle got=%h required IDLE", o);
        end
    endtask

    task automatic test_gap0();
        do_reset();
        pulse_go();
        run_and_check(1'b1, 3, "gap0");
        pulse_go();
        run_and_check(1'b1, 0, "gap0_again");
    endtask

    task automatic test_reset_mid();
        logic [11:0] o;
        do_reset();
        do_load(2'd2, 1'b1, 4'd3, 1'b1, 1'b0);
        pulse_go();
        for (int c = 1; c <= 9; c++) tick();
        o = obs(1'b0);
        checks++;
        if (o[11:3] !== {1'b1, 2'd2, 1'b0, 1'b1, 4'd10}) begin
            errors++;
            $display("FAIL rst_mid_k4 got=%h required send of L2 red start 1", o[11:3]);
        end
        rst = 1'b1; go = 1'b1; stop = 1'b1;
        load_en = 1'b1; load_light = 2'd0; load_color = 1'b0; load_time = 4'd1; load_start = 1'b1;
        tick();
        rst = 1'b0; go = 1'b0; stop = 1'b0; load_en = 1'b0;
        model_reset();
        o = obs(1'b0);
        checks++;
        if (o !== 12'h000) begin
            errors++;
            $display("FAIL rst_mid_outputs got=%h required=000", o);
        end
        pulse_go();
        run_and_check(1'b0, 0, "after_rst");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_default_seq();
        test_load();
        test_stop();
        test_back_to_back();
        test_gap0();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
